// File: rtl/skinny_isw_pkg.sv
// Shared types and constants for the serial masked SKINNY 8-bit S-box.
//   state_e    : FSM states (IDLE, MUL, ACC, DONE)
//   operand_e  : operand encoding, x0..x7 (input bits) then t0..t7 (step results)
//   step_t     : per-step operand selection (p_sel, q_sel, z_sel)
//   r_bits     : fresh random bits consumed per ISW multiplication
//   r_index    : lexicographic position of r_ij (i<j) inside the rnd vector
//   step_cfg   : operands of core step k
//   out_pos    : output bit that receives t_k
//   sel_bit    : fetch one operand bit of a single share
//   set_bit    : copy of a byte with one bit replaced
package skinny_isw_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

  typedef enum logic [3:0] {
    OP_X0, OP_X1, OP_X2, OP_X3, OP_X4, OP_X5, OP_X6, OP_X7,
    OP_T0, OP_T1, OP_T2, OP_T3, OP_T4, OP_T5, OP_T6, OP_T7
  } operand_e;

  typedef struct packed {
    operand_e   p_sel;
    operand_e   q_sel;
    logic [2:0] z_sel;
  } step_t;

  function automatic int r_bits(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  function automatic int r_index(input int shares, input int i, input int j);
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // t_k = NOR(p, q) ^ x[z]
  function automatic step_t step_cfg(input logic [2:0] k);
    step_t s;
    case (k)
      3'd0:    s = '{OP_X7, OP_X6, 3'd4};
      3'd1:    s = '{OP_X3, OP_X2, 3'd0};
      3'd2:    s = '{OP_X2, OP_X1, 3'd6};
      3'd3:    s = '{OP_T0, OP_T1, 3'd5};
      3'd4:    s = '{OP_T1, OP_X3, 3'd1};
      3'd5:    s = '{OP_T2, OP_T3, 3'd7};
      3'd6:    s = '{OP_T3, OP_T0, 3'd3};
      default: s = '{OP_T4, OP_T5, 3'd2};
    endcase
    return s;
  endfunction

  function automatic logic [2:0] out_pos(input logic [2:0] k);
    logic [2:0] p;
    case (k)
      3'd0:    p = 3'd6;
      3'd1:    p = 3'd5;
      3'd2:    p = 3'd2;
      3'd3:    p = 3'd7;
      3'd4:    p = 3'd3;
      3'd5:    p = 3'd1;
      3'd6:    p = 3'd4;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

  // t values live in the t register at their final output position, so a
  // t operand is looked up through out_pos.
  function automatic logic sel_bit(input logic [7:0] x, input logic [7:0] t,
                                   input operand_e op);
    logic [3:0] o;
    o = op;
    if (o[3]) return t[out_pos(o[2:0])];
    else      return x[o[2:0]];
  endfunction

  function automatic logic [7:0] set_bit(input logic [7:0] v, input logic [2:0] pos,
                                         input logic b);
    logic [7:0] r;
    r = v;
    r[pos] = b;
    return r;
  endfunction

endpackage

// File: rtl/isw_and_reg_nshare.sv
// Registered ISW AND gadget for SHARES Boolean shares of one bit.
// Every cross-product (plus its fresh mask) is stored in a register before
// any XOR compression, so the compression never sees unregistered products.
//   clk, rst     : clock, synchronous active-high reset
//   en           : load the product register (MUL phase, randomness present)
//   inv_a, inv_b : complement share 0 of a / b (turns AND into NOR)
//   a, b         : operand shares, bit i = share i
//   rnd          : R_BITS fresh bits, r_ij in lexicographic (i<j) order
//   row          : row i = XOR of product-register row i (output share i)
module isw_and_reg_nshare
  import skinny_isw_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int R_BITS = r_bits(SHARES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inv_a,
  input  logic              inv_b,
  input  logic [SHARES-1:0] a,
  input  logic [SHARES-1:0] b,
  input  logic [R_BITS-1:0] rnd,
  output logic [SHARES-1:0] row
);

  logic [SHARES-1:0]             a_eff;
  logic [SHARES-1:0]             b_eff;
  logic [SHARES-1:0][SHARES-1:0] prod_next;
  logic [SHARES-1:0][SHARES-1:0] prod_reg;

  assign a_eff = a ^ SHARES'(inv_a);
  assign b_eff = b ^ SHARES'(inv_b);

  genvar gi, gj;
  generate
    for (gi = 0; gi < SHARES; gi++) begin : g_row
      for (gj = 0; gj < SHARES; gj++) begin : g_col
        if (gi == gj) begin : g_diag
          assign prod_next[gi][gj] = a_eff[gi] & b_eff[gj];
        end else if (gi < gj) begin : g_upper
          localparam int RI = r_index(SHARES, gi, gj);
          assign prod_next[gi][gj] = (a_eff[gi] & b_eff[gj]) ^ rnd[RI];
        end else begin : g_lower
          // Same r_ij as the mirrored term so every mask cancels in the sum.
          localparam int RI = r_index(SHARES, gj, gi);
          assign prod_next[gi][gj] = (a_eff[gi] & b_eff[gj]) ^ rnd[RI];
        end
      end
      assign row[gi] = ^prod_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
    end else if (en) begin
      prod_reg <= prod_next;
    end
  end

endmodule

// File: rtl/skinny_sbox8_isw_seq.sv
// Serial masked SKINNY 8-bit S-box. The eight NOR/XOR core steps are run one
// after another on a single registered ISW AND gadget: each step takes a MUL
// cycle (products registered) and an ACC cycle (rows compressed into t_k).
// Optional build macro: SBOX8_ISW_RAND_STALL_EN -- MUL waits for rnd_valid.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid / in_ready / in_shares   : input handshake, share i at [8i+7:8i]
//   rnd / rnd_valid / rnd_ready       : fresh randomness, consumed in MUL
//   out_valid / out_ready / out_shares: output handshake, same share layout
module skinny_sbox8_isw_seq
  import skinny_isw_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int R_BITS = r_bits(SHARES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*SHARES-1:0]   in_shares,
  input  logic [R_BITS-1:0]     rnd,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*SHARES-1:0]   out_shares
);

  state_e                  state_reg, state_next;
  logic [2:0]              step_reg;
  logic [SHARES-1:0][7:0]  x_reg;
  logic [SHARES-1:0][7:0]  t_reg;
  logic [SHARES-1:0][7:0]  t_next;
  logic [SHARES-1:0][7:0]  out_reg;
  logic [SHARES-1:0]       a_sh, b_sh, z_sh, row;
  step_t                   cfg;
  logic                    mul_go;

`ifdef SBOX8_ISW_RAND_STALL_EN
  assign mul_go = rnd_valid;
`else
  logic unused_rnd_valid;
  assign unused_rnd_valid = rnd_valid;
  assign mul_go = 1'b1;
`endif

  assign cfg        = step_cfg(step_reg);
  assign in_ready   = (state_reg == IDLE);
  assign rnd_ready  = (state_reg == MUL) & mul_go;
  assign out_valid  = (state_reg == DONE);
  assign out_shares = out_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SHARES; gi++) begin : g_share
      assign a_sh[gi]   = sel_bit(x_reg[gi], t_reg[gi], cfg.p_sel);
      assign b_sh[gi]   = sel_bit(x_reg[gi], t_reg[gi], cfg.q_sel);
      assign z_sh[gi]   = x_reg[gi][cfg.z_sel];
      assign t_next[gi] = set_bit(t_reg[gi], out_pos(step_reg), row[gi] ^ z_sh[gi]);
    end
  endgenerate

  // NOR(p,q) = AND(~p,~q); complementing share 0 complements the shared value.
  isw_and_reg_nshare #(
    .SHARES (SHARES),
    .R_BITS (R_BITS)
  ) u_isw (
    .clk   (clk),
    .rst   (rst),
    .en    (rnd_ready),
    .inv_a (1'b1),
    .inv_b (1'b1),
    .a     (a_sh),
    .b     (b_sh),
    .rnd   (rnd),
    .row   (row)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = MUL;
      MUL:     if (mul_go) state_next = ACC;
      ACC:     state_next = (step_reg == 3'd7) ? DONE : MUL;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= 3'd0;
      x_reg     <= '0;
      t_reg     <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        x_reg <= in_shares;
      end
      if (state_reg == ACC) begin
        t_reg    <= t_next;
        // 3-bit counter: the 7->0 wrap coincides with entering DONE.
        step_reg <= step_reg + 3'd1;
        if (step_reg == 3'd7) begin
          out_reg <= t_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_isw_seq.sv
module tb_skinny_sbox8_isw_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid2, in_ready2, rnd_valid2, rnd_ready2, out_valid2, out_ready2;
  logic [15:0] in_shares2, out_shares2;
  logic [0:0]  rnd2;
  logic        in_valid4, in_ready4, rnd_valid4, rnd_ready4, out_valid4, out_ready4;
  logic [31:0] in_shares4, out_shares4;
  logic [5:0]  rnd4;

  int n_checks = 0;
  int n_pass   = 0;

  skinny_sbox8_isw_seq #(.SHARES(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_shares(in_shares2),
    .rnd(rnd2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_shares(out_shares2)
  );

  skinny_sbox8_isw_seq #(.SHARES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_shares(in_shares4),
    .rnd(rnd4), .rnd_valid(rnd_valid4), .rnd_ready(rnd_ready4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_shares(out_shares4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference SKINNY S8: four MIX rounds separated by bit permutations.
  function automatic logic [7:0] sb_mix(input logic [7:0] x);
    return ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
  endfunction
  function automatic logic [7:0] sb_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] v;
    v = sb_mix(x);
    v = sb_mix(sb_perm(v));
    v = sb_mix(sb_perm(v));
    v = sb_mix(sb_perm(v));
    return (v & 8'hF9) | ((v >> 1) & 8'h02) | ((v << 1) & 8'h04);
  endfunction

  // One SHARES=2 evaluation: share0 = m, share1 = x ^ m.
  task automatic run2(input logic [7:0] x, input logic [7:0] m, input bit stall,
                      input bit hold, output logic [7:0] y, output int lat);
    logic [15:0] snap;
    in_shares2 = {x ^ m, m};
    in_valid2  = 1'b1;
    tick();
    in_valid2  = 1'b0;
    in_shares2 = 16'($urandom());
    lat = 0;
    if (!stall) check("rnd_ready_mul", 32'(rnd_ready2), 32'd1);
    while (!out_valid2 && lat < 64) begin
      rnd2       = 1'($urandom());
      rnd_valid2 = !(stall && lat >= 4 && lat <= 6);
      tick();
      lat++;
      if (!stall && lat == 1) check("rnd_ready_acc", 32'(rnd_ready2), 32'd0);
    end
    rnd_valid2 = 1'b1;
    if (!out_valid2) check("timeout_s2", 32'(out_valid2), 32'd1);
    y    = out_shares2[15:8] ^ out_shares2[7:0];
    snap = out_shares2;
    if (hold) begin
      repeat (10) begin
        tick();
        check("hold_stable", 32'(out_shares2), 32'(snap));
        check("hold_in_ready", 32'(in_ready2), 32'd0);
      end
      check("hold_out_valid", 32'(out_valid2), 32'd1);
    end
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    if (hold) begin
      check("post_in_ready", 32'(in_ready2), 32'd1);
      check("post_out_valid", 32'(out_valid2), 32'd0);
      check("post_shares_kept", 32'(out_shares2), 32'(snap));
    end
    $display("txn s2 in=%02h mask=%02h out=%02h lat=%0d", x, m, y, lat);
  endtask

  task automatic run4(input logic [7:0] x, output logic [7:0] y,
                      output logic [7:0] s0, output int lat);
    logic [7:0] m0, m1, m2;
    m0 = 8'($urandom());
    m1 = 8'($urandom());
    m2 = 8'($urandom());
    in_shares4 = {x ^ m0 ^ m1 ^ m2, m2, m1, m0};
    in_valid4  = 1'b1;
    tick();
    in_valid4  = 1'b0;
    in_shares4 = $urandom();
    lat = 0;
    while (!out_valid4 && lat < 64) begin
      rnd4 = 6'($urandom());
      tick();
      lat++;
    end
    if (!out_valid4) check("timeout_s4", 32'(out_valid4), 32'd1);
    y  = out_shares4[31:24] ^ out_shares4[23:16] ^ out_shares4[15:8] ^ out_shares4[7:0];
    s0 = out_shares4[7:0];
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    $display("txn s4 in=%02h out=%02h lat=%0d", x, y, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] y, s0;
    int         lat;
    int         leak_cnt;
    int         lat_bad;
    int         stall_lat;

    rst = 1'b1;
    in_valid2 = 1'b0; in_shares2 = '0; rnd2 = '0; rnd_valid2 = 1'b1; out_ready2 = 1'b0;
    in_valid4 = 1'b0; in_shares4 = '0; rnd4 = '0; rnd_valid4 = 1'b1; out_ready4 = 1'b0;
    repeat (3) tick();
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    check("rst_in_ready2", 32'(in_ready2), 32'd1);
    check("rst_rnd_ready2", 32'(rnd_ready2), 32'd0);
    check("rst_out_shares2", 32'(out_shares2), 32'd0);
    check("rst_out_valid4", 32'(out_valid4), 32'd0);
    check("rst_in_ready4", 32'(in_ready4), 32'd1);
    check("rst_rnd_ready4", 32'(rnd_ready4), 32'd0);
    check("rst_out_shares4", out_shares4, 32'd0);
    rst = 1'b0;

    run2(8'h00, 8'h00, 1'b0, 1'b0, y, lat);
    check("s2_x00", 32'(y), 32'h65);
    check("s2_x00_lat", 32'(lat), 32'd16);
    run2(8'hFF, 8'hA5, 1'b0, 1'b0, y, lat);
    check("s2_xFF", 32'(y), 32'hFF);
    run2(8'h01, 8'($urandom()), 1'b0, 1'b0, y, lat);
    check("s2_x01", 32'(y), 32'h4C);
    run2(8'h3C, 8'($urandom()), 1'b0, 1'b1, y, lat);
    check("s2_hold_x3C", 32'(y), 32'(sbox_ref(8'h3C)));

`ifdef SBOX8_ISW_RAND_STALL_EN
    stall_lat = 19;
`else
    stall_lat = 16;
`endif
    run2(8'h01, 8'($urandom()), 1'b1, 1'b0, y, lat);
    check("stall_x01", 32'(y), 32'h4C);
    check("stall_lat", 32'(lat), 32'(stall_lat));

    // Reset on the 7th edge after acceptance.
    in_shares2 = {8'hEE, 8'h11};
    in_valid2  = 1'b1;
    tick();
    in_valid2  = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid2), 32'd0);
    check("midrst_in_ready", 32'(in_ready2), 32'd1);
    run2(8'h01, 8'($urandom()), 1'b0, 1'b0, y, lat);
    check("after_rst_x01", 32'(y), 32'h4C);
    check("after_rst_lat", 32'(lat), 32'd16);

    leak_cnt = 0;
    lat_bad  = 0;
    for (int v = 0; v < 256; v++) begin
      run4(8'(v), y, s0, lat);
      check($sformatf("s4_x%02h", v), 32'(y), 32'(sbox_ref(8'(v))));
      if (s0 == sbox_ref(8'(v))) leak_cnt++;
      if (lat != 16) lat_bad++;
    end
    check("s4_latency_bad", 32'(lat_bad), 32'd0);
    check("s4_share0_leak", 32'(leak_cnt < 32), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
